// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the unified-memory arbiter.
//   state_e       - arbiter sequencing states
//   SZ_*          - d_size encodings (2'b11 is reserved)
//   DEF_*         - default memory window
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    WR     = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [31:0] DEF_START_ADDRESS = 32'h0100_0000;
  localparam int unsigned DEF_MEM_SIZE      = 1048576;

endpackage

// File: rtl/mem_arbiter_store_merge.sv
// store_merge: folds a right-aligned sub-word store into the old memory word.
//   old_i    - word currently in memory
//   wdata_i  - store data, right-aligned
//   size_i   - SZ_BYTE / SZ_HALF replace the low byte / half, anything else
//              passes wdata_i through
//   merged_o - word to write back
module store_merge
  import mem_arb_pkg::*;
(
  input  logic [31:0] old_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  output logic [31:0] merged_o
);

  always_comb begin
    merged_o = wdata_i;
    case (size_i)
      SZ_BYTE: merged_o = {old_i[31:8],  wdata_i[7:0]};
      SZ_HALF: merged_o = {old_i[31:16], wdata_i[15:0]};
      default: merged_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port byte-addressed memory between the fetch
// port (f_*) and the load/store port (d_*). Sub-word stores become
// read-modify-write sequences; out-of-range addresses and the reserved size
// are answered with err and never reach memory.
//   clk/reset        - clock, synchronous active-high reset
//   f_req/f_addr     - fetch request; f_gnt, f_rvalid/f_rdata/f_err response
//   d_req/d_we/d_size/d_addr/d_wdata - data request; d_gnt, d_rvalid/d_rdata/d_err
//   mem_*            - memory side (combinational read, posedge write)
// Option: MEM_ARB_ROUND_ROBIN_EN alternates grants on simultaneous requests
// instead of fixed data-over-fetch priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter logic [31:0] START_ADDRESS = DEF_START_ADDRESS,
  parameter int unsigned MEM_SIZE      = DEF_MEM_SIZE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_gnt,
  output logic        f_rvalid,
  output logic [31:0] f_rdata,
  output logic        f_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_w_enable,
  input  logic [31:0] mem_data_out
);

  // Highest legal word address, in 33 bits so the window cannot wrap.
  localparam logic [32:0] LAST_OK = {1'b0, START_ADDRESS} + 33'(MEM_SIZE) - 33'd4;

  state_e      state_q, state_d;
  logic [31:0] addr_q, wbuf_q, merged;
  logic [1:0]  size_q;
  logic        src_q;               // 1 = data port owns the sequence
  logic        f_rvalid_q, d_rvalid_q, f_err_q, d_err_q;
  logic [31:0] f_rdata_q, d_rdata_q;

  logic        sel_d, sel_f, gnt_any, req_err, req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_q;                     // 1 = data port got the last grant
  assign sel_d = d_req && !(f_req && last_q);
`else
  assign sel_d = d_req;
`endif
  assign sel_f = f_req && !sel_d;

  // Reset gates gnt and the write strobe so a sequence cut short by reset
  // can neither start a new one nor touch memory.
  assign gnt_any  = (state_q == IDLE) && !reset && (sel_d || sel_f);
  assign f_gnt    = gnt_any && sel_f;
  assign d_gnt    = gnt_any && sel_d;

  assign req_addr = sel_d ? d_addr : f_addr;
  assign req_we   = sel_d && d_we;
  assign req_size = sel_d ? d_size : SZ_WORD;
  assign req_err  = ({1'b0, req_addr} < {1'b0, START_ADDRESS}) ||
                    ({1'b0, req_addr} > LAST_OK) || (req_size == 2'b11);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (gnt_any && !req_err) begin
          if (!req_we)                  state_d = RD;
          else if (req_size == SZ_WORD) state_d = WR;
          else                          state_d = RMW_RD;
        end
      end
      RMW_RD:  state_d = RMW_WR;
      default: state_d = IDLE;
    endcase
  end

  store_merge u_merge (
    .old_i    (mem_data_out),
    .wdata_i  (wbuf_q),
    .size_i   (size_q),
    .merged_o (merged)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= START_ADDRESS;
      wbuf_q     <= '0;
      size_q     <= SZ_WORD;
      src_q      <= 1'b0;
      f_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      f_err_q    <= 1'b0;
      d_err_q    <= 1'b0;
      f_rdata_q  <= '0;
      d_rdata_q  <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      f_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      f_err_q    <= 1'b0;
      d_err_q    <= 1'b0;

      if (gnt_any) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_q <= sel_d;
`endif
        if (req_err) begin
          // Answer straight from IDLE; address register keeps its last value.
          if (sel_d) begin
            d_rvalid_q <= 1'b1;
            d_err_q    <= 1'b1;
            d_rdata_q  <= '0;
          end else begin
            f_rvalid_q <= 1'b1;
            f_err_q    <= 1'b1;
            f_rdata_q  <= '0;
          end
        end else begin
          addr_q <= req_addr;
          size_q <= req_size;
          src_q  <= sel_d;
          if (req_we) wbuf_q <= d_wdata;
        end
      end

      case (state_q)
        RD: begin
          if (src_q) begin
            d_rvalid_q <= 1'b1;
            d_rdata_q  <= mem_data_out;
          end else begin
            f_rvalid_q <= 1'b1;
            f_rdata_q  <= mem_data_out;
          end
        end
        WR, RMW_WR: begin
          d_rvalid_q <= 1'b1;
          d_rdata_q  <= '0;
        end
        RMW_RD:  wbuf_q <= merged;
        default: ;
      endcase
    end
  end

  assign mem_address  = addr_q;
  assign mem_data_in  = wbuf_q;
  assign mem_w_enable = !reset && ((state_q == WR) || (state_q == RMW_WR));

  assign f_rvalid = f_rvalid_q;
  assign f_rdata  = f_rdata_q;
  assign f_err    = f_err_q;
  assign d_rvalid = d_rvalid_q;
  assign d_rdata  = d_rdata_q;
  assign d_err    = d_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter against a byte-array memory
// model. Expected values are hand-computed constants.
module tb_mem_arbiter;

  localparam logic [31:0] SA = 32'h0100_0000;

  logic        clk = 1'b0, reset = 1'b1;
  logic        f_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] f_addr = SA, d_addr = SA, d_wdata = '0;
  logic [1:0]  d_size = 2'b10;
  logic        f_gnt, f_rvalid, f_err, d_gnt, d_rvalid, d_err, mem_w_enable;
  logic [31:0] f_rdata, d_rdata, mem_address, mem_data_in, mem_data_out;

  logic [7:0]  mem [0:1048575];
  logic        pre_we = 1'b0;
  logic [31:0] pre_addr = '0, pre_data = '0;
  int          checks = 0, errors = 0, we_cnt = 0, we_base = 0;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .f_rdata(f_rdata), .f_err(f_err),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .d_err(d_err),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_w_enable(mem_w_enable), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - SA;
    return off[19:0];
  endfunction

  always_comb begin
    mem_data_out = '0;
    for (int b = 0; b < 4; b++)
      mem_data_out[8*b +: 8] = mem[idx(mem_address + 32'(b))];
  end

  always @(posedge clk) begin
    if (pre_we) begin
      for (int b = 0; b < 4; b++) mem[idx(pre_addr + 32'(b))] <= pre_data[8*b +: 8];
    end else if (mem_w_enable) begin
      for (int b = 0; b < 4; b++) mem[idx(mem_address + 32'(b))] <= mem_data_in[8*b +: 8];
    end
    if (mem_w_enable) we_cnt <= we_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    cyc();
    pre_we = 1'b0;
  endtask

  // Single-cycle error response; memory and mem_address must stay untouched.
  task automatic err_case(input string tag, input logic [31:0] a,
                          input logic we, input logic [1:0] sz);
    we_base = we_cnt;
    d_req = 1'b1; d_we = we; d_size = sz; d_addr = a; d_wdata = 32'h1234_5678;
    #1 chk({tag, "_gnt"}, 32'(d_gnt), 32'd1);
    cyc(); d_req = 1'b0; #1;
    chk({tag, "_rvalid"}, 32'(d_rvalid), 32'd1);
    chk({tag, "_err"},    32'(d_err),    32'd1);
    chk({tag, "_rdata"},  d_rdata,       32'h0);
    chk({tag, "_addr"},   mem_address,   SA + 32'h10);
    cyc();
    chk({tag, "_rv_off"}, 32'(d_rvalid), 32'd0);
    chk({tag, "_nowr"},   32'(we_cnt - we_base), 32'd0);
  endtask

  initial begin
    // Preload while reset holds the arbiter quiet.
    cyc();
    preload(SA,                32'h00A0_0093);
    preload(SA + 32'h20,       32'h1122_3344);
    preload(SA + 32'h30,       32'h5566_7788);
    preload(32'h010F_FFFC,     32'hCAFE_F00D);
    reset = 1'b0; #1;
    chk("rst_addr",   mem_address,          SA);
    chk("rst_din",    mem_data_in,          32'h0);
    chk("rst_we",     32'(mem_w_enable),    32'd0);
    chk("rst_valid",  {30'd0, f_rvalid, d_rvalid}, 32'd0);
    chk("rst_err",    {30'd0, f_err, d_err}, 32'd0);
    chk("rst_frdata", f_rdata,              32'h0);
    chk("rst_drdata", d_rdata,              32'h0);
    cyc();

    // Fetch read: gnt at 0, rvalid at 2.
    f_req = 1'b1; f_addr = SA; #1;
    chk("f_gnt0", 32'(f_gnt), 32'd1);
    cyc(); f_req = 1'b0; #1;
    chk("f_rv1", 32'(f_rvalid), 32'd0);
    cyc();
    chk("f_rv2",    32'(f_rvalid), 32'd1);
    chk("f_rdata2", f_rdata,       32'h00A0_0093);
    chk("f_err2",   32'(f_err),    32'd0);
    cyc();
    chk("f_rv3", 32'(f_rvalid), 32'd0);

    // Simultaneous fetch + load; last grant was fetch, so data wins either way.
    f_req = 1'b1; f_addr = SA;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = SA + 32'h20; #1;
    chk("both_dgnt", 32'(d_gnt), 32'd1);
    chk("both_fgnt", 32'(f_gnt), 32'd0);
    cyc(); d_req = 1'b0; #1;
    chk("both_fgnt1", 32'(f_gnt), 32'd0);
    cyc();
    chk("both_drv",  32'(d_rvalid), 32'd1);
    chk("both_drd",  d_rdata,       32'h1122_3344);
    chk("both_fgnt2", 32'(f_gnt),   32'd1);
    cyc(); f_req = 1'b0;
    cyc();
    chk("both_frv", 32'(f_rvalid), 32'd1);
    chk("both_frd", f_rdata,       32'h00A0_0093);
    cyc();

    // Byte store into 11223344 -> 112233AB, ack at cycle 3.
    d_req = 1'b1; d_we = 1'b1; d_size = 2'b00; d_addr = SA + 32'h20;
    d_wdata = 32'hFFFF_FFAB; #1;
    chk("sb_gnt", 32'(d_gnt), 32'd1);
    cyc(); d_req = 1'b0; #1;
    chk("sb_we1", 32'(mem_w_enable), 32'd0);
    chk("sb_rv1", 32'(d_rvalid),     32'd0);
    cyc();
    chk("sb_we2",  32'(mem_w_enable), 32'd1);
    chk("sb_din2", mem_data_in,       32'h1122_33AB);
    chk("sb_rv2",  32'(d_rvalid),     32'd0);
    cyc();
    chk("sb_rv3",  32'(d_rvalid),     32'd1);
    chk("sb_err3", 32'(d_err),        32'd0);
    chk("sb_rd3",  d_rdata,           32'h0);
    chk("sb_we3",  32'(mem_w_enable), 32'd0);
    cyc();

    // Simultaneous again, right after a data grant.
    f_req = 1'b1; f_addr = SA;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = SA + 32'h20; #1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    chk("rr_fgnt", 32'(f_gnt), 32'd1);
    chk("rr_dgnt", 32'(d_gnt), 32'd0);
    cyc(); f_req = 1'b0; #1;
    chk("rr_dgnt1", 32'(d_gnt), 32'd0);
    cyc();
    chk("rr_frv",   32'(f_rvalid), 32'd1);
    chk("rr_frd",   f_rdata,       32'h00A0_0093);
    chk("rr_dgnt2", 32'(d_gnt),    32'd1);
    cyc(); d_req = 1'b0;
    cyc();
    chk("rr_drv", 32'(d_rvalid), 32'd1);
    chk("rr_drd", d_rdata,       32'h1122_33AB);
`else
    chk("fp_dgnt", 32'(d_gnt), 32'd1);
    chk("fp_fgnt", 32'(f_gnt), 32'd0);
    cyc(); d_req = 1'b0; #1;
    cyc();
    chk("fp_drv",   32'(d_rvalid), 32'd1);
    chk("fp_drd",   d_rdata,       32'h1122_33AB);
    chk("fp_fgnt2", 32'(f_gnt),    32'd1);
    cyc(); f_req = 1'b0;
    cyc();
    chk("fp_frv", 32'(f_rvalid), 32'd1);
    chk("fp_frd", f_rdata,       32'h00A0_0093);
`endif
    cyc();

    // Word store, exactly one write strobe, then read back.
    we_base = we_cnt;
    d_req = 1'b1; d_we = 1'b1; d_size = 2'b10; d_addr = SA + 32'h10;
    d_wdata = 32'hDEAD_BEEF; #1;
    chk("sw_gnt", 32'(d_gnt), 32'd1);
    cyc(); d_req = 1'b0; #1;
    chk("sw_we1",  32'(mem_w_enable), 32'd1);
    chk("sw_din1", mem_data_in,       32'hDEAD_BEEF);
    cyc();
    chk("sw_rv2",  32'(d_rvalid),     32'd1);
    chk("sw_we2",  32'(mem_w_enable), 32'd0);
    chk("sw_cnt",  32'(we_cnt - we_base), 32'd1);
    d_req = 1'b1; d_we = 1'b0; #1;
    chk("lw_gnt", 32'(d_gnt), 32'd1);
    cyc(); d_req = 1'b0;
    cyc();
    chk("lw_rv", 32'(d_rvalid), 32'd1);
    chk("lw_rd", d_rdata,       32'hDEAD_BEEF);
    cyc();

    // Error cases.
    err_case("e_low",   32'h00FF_FFFC, 1'b0, 2'b10);
    err_case("e_high",  32'h010F_FFFD, 1'b0, 2'b10);
    err_case("e_rsvld", SA,            1'b0, 2'b11);
    err_case("e_rsvst", SA,            1'b1, 2'b11);

    // Top in-range word is legal.
    f_req = 1'b1; f_addr = 32'h010F_FFFC; #1;
    chk("top_gnt", 32'(f_gnt), 32'd1);
    cyc(); f_req = 1'b0;
    cyc();
    chk("top_rv",  32'(f_rvalid), 32'd1);
    chk("top_err", 32'(f_err),    32'd0);
    chk("top_rd",  f_rdata,       32'hCAFE_F00D);
    cyc();

    // Reset during RMW_RD: no ack, no write.
    we_base = we_cnt;
    d_req = 1'b1; d_we = 1'b1; d_size = 2'b01; d_addr = SA + 32'h30;
    d_wdata = 32'h0000_AAAA; #1;
    chk("rr_rmw_gnt", 32'(d_gnt), 32'd1);
    cyc(); d_req = 1'b0; reset = 1'b1; #1;
    chk("rst_mid_we", 32'(mem_w_enable), 32'd0);
    cyc(); reset = 1'b0; #1;
    chk("rst_mid_rv",   32'(d_rvalid),     32'd0);
    chk("rst_mid_we2",  32'(mem_w_enable), 32'd0);
    chk("rst_mid_addr", mem_address,       SA);
    cyc();
    chk("rst_mid_rv3",  32'(d_rvalid), 32'd0);
    chk("rst_mid_cnt",  32'(we_cnt - we_base), 32'd0);
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = SA + 32'h30; #1;
    chk("rst_ld_gnt", 32'(d_gnt), 32'd1);
    cyc(); d_req = 1'b0;
    cyc();
    chk("rst_ld_rv", 32'(d_rvalid), 32'd1);
    chk("rst_ld_rd", d_rdata,       32'h5566_7788);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
